// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the push-button conditioner.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_t;

    localparam int BTN_SYNC_STAGES = 2;

endpackage

// File: rtl/button_conditioner_sync_2ff.sv
// Single-bit synchroniser for the asynchronous button pad, cleared by the
// synchronous reset so a held button is re-detected after reset.
module sync_2ff
    import button_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [BTN_SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[BTN_SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[BTN_SYNC_STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Debounced push-button conditioner: clean level plus one-cycle press/release
// pulses. Long-press pulse is built only when BTN_LONG_PRESS_EN is defined.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LONG_CYCLES     = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic button_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_param_check
        $error("button_conditioner: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
    end

    logic       s2;
    btn_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic level_q, level_d;
    logic press_q, press_d;
    logic release_q, release_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (button_raw),
        .q_o (s2)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s2) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                    level_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!s2) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (s2) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

`ifdef BTN_LONG_PRESS_EN
    localparam int            HW       = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    logic [HW-1:0] hold_q, hold_d;
    logic          long_q, long_d;

    // Saturating at HOLD_MAX guarantees a single pulse per press.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (press_d || state_d == IDLE) begin
            hold_d = '0;
        end else if (state_q == PRESSED || state_q == RELEASE_WAIT) begin
            if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + HOLD_ONE;
                long_d = (hold_q == HOLD_MAX - HOLD_ONE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign btn_long = long_q;
`else
    assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_button_conditioner;

    typedef enum int {EV_PRESS, EV_RELEASE, EV_LONG} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
    } ev_t;

    localparam int LAT = 7;   // DEBOUNCE_CYCLES + 3

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic button_raw = 1'b0;
    logic btn_level, btn_press, btn_release, btn_long;

    ev_t  exp_q[$];
    int   cyc = 0;
    logic rst_seen = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_level = 1'b0;
    logic exp_p, exp_r, exp_l;
    bit   done = 1'b0;
    bit   fin = 1'b0;

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .button_raw  (button_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    function automatic void check(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endfunction

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(ev_kind_t k, int c);
        exp_q.push_back('{kind: k, cyc: c});
    endtask

    // Monitor: pops expected events when their cycle comes up, checks every cycle.
    always @(negedge clk) begin
        if (done) begin
            if (!fin) begin
                check("pending_events", exp_q.size(), 0);
                fin = 1'b1;
            end
        end else begin
            exp_p = 1'b0;
            exp_r = 1'b0;
            exp_l = 1'b0;
            if (rst_seen) begin
                exp_level = 1'b0;
            end else begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    check("missed_event_cycle", cyc, exp_q[0].cyc);
                    void'(exp_q.pop_front());
                end
                while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    case (exp_q[0].kind)
                        EV_PRESS:   begin exp_p = 1'b1; exp_level = 1'b1; end
                        EV_RELEASE: begin exp_r = 1'b1; exp_level = 1'b0; end
                        default:    exp_l = 1'b1;
                    endcase
                    void'(exp_q.pop_front());
                end
            end
            check("btn_press",   int'(btn_press),   int'(exp_p));
            check("btn_release", int'(btn_release), int'(exp_r));
            check("btn_long",    int'(btn_long),    int'(exp_l));
            check("btn_level",   int'(btn_level),   int'(exp_level));
        end
    end

    initial begin
        int c;
        rst = 1'b1;
        button_raw = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(5);

        // Clean press held 40 cycles past the press, then a short release bounce.
        c = cyc;
        button_raw = 1'b1;
        push(EV_PRESS, c + LAT);
`ifdef BTN_LONG_PRESS_EN
        push(EV_LONG, c + LAT + 20);
`endif
        idle(LAT + 40);
        button_raw = 1'b0;
        idle(2);
        button_raw = 1'b1;
        idle(10);
        button_raw = 1'b0;
        push(EV_RELEASE, cyc + LAT);
        idle(15);

        // Glitch of 3 cycles: rejected.
        button_raw = 1'b1;
        idle(3);
        button_raw = 1'b0;
        idle(15);

        // Press released 10 cycles later: no long pulse.
        c = cyc;
        button_raw = 1'b1;
        push(EV_PRESS, c + LAT);
        idle(LAT + 10);
        button_raw = 1'b0;
        push(EV_RELEASE, c + LAT + 10 + LAT);
        idle(30);

        // Reset while PRESSED with the button held; held button re-detected.
        c = cyc;
        button_raw = 1'b1;
        push(EV_PRESS, c + LAT);
        idle(12);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        c = cyc;
        push(EV_PRESS, c + LAT);
        idle(LAT + 10);
        button_raw = 1'b0;
        push(EV_RELEASE, cyc + LAT);
        idle(15);

        // Rapid toggling from released state.
        for (int i = 0; i < 50; i++) begin
            button_raw = ~button_raw;
            idle(1);
        end
        button_raw = 1'b0;
        idle(15);

        // Rapid toggling while pressed; hold time keeps accumulating.
        c = cyc;
        button_raw = 1'b1;
        push(EV_PRESS, c + LAT);
`ifdef BTN_LONG_PRESS_EN
        push(EV_LONG, c + LAT + 20);
`endif
        idle(12);
        for (int i = 0; i < 50; i++) begin
            button_raw = ~button_raw;
            idle(1);
        end
        button_raw = 1'b1;
        idle(10);
        button_raw = 1'b0;
        push(EV_RELEASE, cyc + LAT);
        idle(15);

        done = 1'b1;
        idle(3);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the raw push-button input into clean, single-cycle events for the digit-select counter. Its `btn_press` output drives that counter's `button` input. The block synchronises the asynchronous pad signal, debounces both edges with a programmable stability window, and emits one-cycle press/release pulses plus a debounced level. An optional long-press detector is compiled in by macro.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable synchronised samples required to accept a level change; must be ≥ 1.
- `LONG_CYCLES`, default 25000000: hold time in cycles, measured from the `btn_press` cycle, before `btn_long` fires; must be ≥ 1.
- `clk` input 1: single clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `button_raw` input 1: asynchronous, bouncing pad input; high = pressed.
- `btn_level` output 1: debounced level, registered.
- `btn_press` output 1: one-cycle pulse on accepted press.
- `btn_release` output 1: one-cycle pulse on accepted release.
- `btn_long` output 1: one-cycle pulse on long hold; constant 0 when the feature is compiled out.

## Operation
- Synchroniser: 2 flops, `button_raw` → `s1` → `s2`. The FSM sees only `s2`.
- Debounce counter `cnt` has width `$clog2(DEBOUNCE_CYCLES+1)`.
- FSM states and transitions:
  - IDLE:
    - `s2`=1 → PRESS_WAIT, `cnt`←1.
  - PRESS_WAIT:
    - `s2`=0 → IDLE, `cnt`←0, no pulse (glitch rejected).
    - `s2`=1 and `cnt`==`DEBOUNCE_CYCLES` → PRESSED, `cnt`←0, `btn_press`←1, `btn_level`←1.
    - `s2`=1 otherwise → `cnt`+1.
  - PRESSED:
    - `s2`=0 → RELEASE_WAIT, `cnt`←1.
  - RELEASE_WAIT:
    - `s2`=1 → PRESSED, `cnt`←0, no pulse.
    - `s2`=0 and `cnt`==`DEBOUNCE_CYCLES` → IDLE, `cnt`←0, `btn_release`←1, `btn_level`←0.
    - `s2`=0 otherwise → `cnt`+1.
- `btn_press`, `btn_release` and `btn_long` are registered and default to 0 every cycle. Each is high for exactly one cycle per event.
- `cnt` never exceeds `DEBOUNCE_CYCLES`; no wrap is possible.
- At most one of `btn_press` / `btn_release` is high in any cycle.
- Reset:
  - State ← IDLE.
  - `s1`, `s2`, `cnt`, hold counter ← 0.
  - All outputs ← 0.
- Reset mid-operation discards any pending press or release.
- If `button_raw` is still high after reset deasserts, a fresh press is detected normally and reported.

## Timing
- Press latency: `button_raw` rises and stays high → `btn_press` and `btn_level` are high after posedge number `DEBOUNCE_CYCLES`+3, counted from the first posedge sampling the new value.
- Release latency: `DEBOUNCE_CYCLES`+3 edges, same counting.
- Breakdown of the +3: 2 synchroniser stages plus 1 IDLE→WAIT entry.
- A bounce shorter than `DEBOUNCE_CYCLES`+1 synchronised samples produces no pulse and no level change.
- Minimum pulse spacing: press→release ≥ `DEBOUNCE_CYCLES`+1 cycles.

## Configuration
- Macro `BTN_LONG_PRESS_EN`.
- Defined:
  - A hold counter of width `$clog2(LONG_CYCLES+1)` clears to 0 in the `btn_press` cycle.
  - It increments each cycle in PRESSED or RELEASE_WAIT and saturates at `LONG_CYCLES`.
  - `btn_long` pulses once, exactly `LONG_CYCLES` cycles after the `btn_press` cycle, provided `btn_release` has not occurred.
  - Only one pulse per press.
  - The counter clears on entering IDLE.
- Undefined: no hold counter is synthesised and `btn_long` is tied to 0. The port list is identical in both builds.

## Structure
- Package `button_pkg`:
  - State typedef `btn_state_t` {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT}.
  - Constant `BTN_SYNC_STAGES` = 2.
- Sub-module `sync_2ff`: a 1-bit two-flop synchroniser with the same synchronous reset. Everything else is inline.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20.
- Clean press: raw 0→1 held → `btn_press`=1 for exactly one cycle after edge 7; `btn_level`=1 from that cycle onward.
- Glitch: raw high for 3 cycles, then low → `btn_press` never asserts, `btn_level` stays 0, FSM returns to IDLE.
- Release and release bounce:
  - After a press, raw low for 2 cycles then high → no `btn_release`.
  - Then raw low held → `btn_release` one cycle after edge 7; `btn_level` 0.
- Long press (macro defined): hold 40 cycles after `btn_press` → `btn_long` exactly once, 20 cycles after the `btn_press` cycle.
  - Release at cycle 10 → no `btn_long`.
  - Macro undefined → `btn_long` is always 0.
- Reset mid-hold: assert `rst` in PRESSED with raw high → all outputs 0 the next cycle; after `rst` deasserts, `btn_press` asserts again after edge 7.
- Rapid toggling: raw alternates every cycle for 50 cycles → no pulses, `btn_level` unchanged.
